// File: rtl/mult_seq_ctrl.sv
// Sequencer for the double-precision unsigned multiply program: reads operand pairs,
// multiplies them with a 16-step shift-add datapath and writes big-endian products back.
module mult_seq_ctrl #(
  parameter int NUM_PAIRS = 16,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 64,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic          own_mem,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data
);

  localparam int KW = $clog2(NUM_PAIRS + 1);

  typedef enum logic [2:0] {IDLE, RD, MUL, WR, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   pair_cnt;
  logic [3:0]      phase;
  logic [23:0]     rd_buf;
  logic [31:0]     acc;
  logic [31:0]     mcand;
  logic [15:0]     mult;
  logic [31:0]     acc_next;
  logic [7:0]      wr_byte;

  function automatic logic [AW-1:0] addr_of(input int base, input logic [KW-1:0] k, input int off);
    return AW'(base + 4 * int'(k) + off);
  endfunction

  always_comb begin
    acc_next = acc;
    if (mult[0]) acc_next = acc + mcand;
  end

  // Byte following the one currently on the write bus; the MSB is launched on WR entry.
  always_comb begin
    wr_byte = acc[7:0];
    case (phase[1:0])
      2'd0:    wr_byte = acc[23:16];
      2'd1:    wr_byte = acc[15:8];
      default: wr_byte = acc[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pair_cnt    <= '0;
      phase       <= '0;
      rd_buf      <= '0;
      acc         <= '0;
      mcand       <= '0;
      mult        <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RD;
            pair_cnt <= '0;
            phase    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            mem_addr <= addr_of(SRC_BASE, KW'(0), 0);
          end
        end

        // Memory is registered, so each byte lands one cycle after its address.
        RD: begin
          phase <= phase + 4'd1;
          if (phase < 4'd3) mem_addr <= addr_of(SRC_BASE, pair_cnt, int'(phase) + 1);
          if (phase != 4'd0 && phase < 4'd4) rd_buf <= {rd_buf[15:0], mem_rd_data};
          if (phase == 4'd4) begin
            mcand <= {16'h0000, rd_buf[23:8]};
            mult  <= {rd_buf[7:0], mem_rd_data};
            acc   <= '0;
            phase <= '0;
            state <= MUL;
          end
        end

        MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mult  <= mult >> 1;
          phase <= phase + 4'd1;
          if (phase == 4'd15) begin
            state       <= WR;
            phase       <= '0;
            mem_wr_en   <= 1'b1;
            mem_addr    <= addr_of(DST_BASE, pair_cnt, 0);
            mem_wr_data <= acc_next[31:24];
          end
        end

        WR: begin
          phase <= phase + 4'd1;
          if (phase < 4'd3) begin
            mem_addr    <= addr_of(DST_BASE, pair_cnt, int'(phase) + 1);
            mem_wr_data <= wr_byte;
          end else begin
            mem_wr_en <= 1'b0;
            phase     <= '0;
            pair_cnt  <= pair_cnt + KW'(1);
            if (int'(pair_cnt) + 1 == NUM_PAIRS) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= RD;
              mem_addr <= addr_of(SRC_BASE, pair_cnt + KW'(1), 0);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign own_mem = busy;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized scoreboard bench for mult_seq_ctrl: a byte-wide registered memory model,
// expected write stream from plain A*B products, and run-level timing checks.
module tb_mult_seq_ctrl;
  localparam int NP       = 16;
  localparam int DST      = 64;
  localparam int RUN_LEN  = 25 * NP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       done, busy, own_mem, mem_wr_en;
  logic [7:0] mem_addr, mem_wr_data, rd_data;

  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = '0;
  logic [7:0] tb_data = '0;

  typedef struct {logic [7:0] addr; logic [7:0] data;} wr_t;
  wr_t exp_q[$];

  logic [15:0] op_a [NP];
  logic [15:0] op_b [NP];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int busy_cnt = 0;
  int wr_cnt = 0;
  logic done_q = 1'b0;

  mult_seq_ctrl #(.NUM_PAIRS(NP), .SRC_BASE(0), .DST_BASE(DST), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
    .own_mem(own_mem), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered data memory; the bench's own loader port takes priority over the DUT.
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    rd_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected byte per write strobe and checks per-run cycle counts.
  always @(negedge clk) begin
    wr_t e;
    check("own_mem_vs_busy", {31'd0, own_mem}, {31'd0, busy});
    if (!rst_n) begin
      busy_cnt = 0;
      wr_cnt   = 0;
    end else begin
      if (busy) busy_cnt++;
      if (mem_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: addr %h data %h with empty queue", mem_addr, mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
          check($sformatf("wr_data@%0h", e.addr), {24'd0, mem_wr_data}, {24'd0, e.data});
        end
      end
      if (done && !done_q) begin
        check("busy_cycles", busy_cnt, RUN_LEN);
        check("wr_cycles", wr_cnt, 4 * NP);
        busy_cnt = 0;
        wr_cnt   = 0;
      end
    end
    done_q = done;
  end

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input int a, input logic [7:0] d);
    tb_we   = 1'b1;
    tb_addr = 8'(a);
    tb_data = d;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  task automatic load_memory(input logic [7:0] fill);
    for (int k = 0; k < NP; k++) begin
      load_byte(4 * k + 0, op_a[k][15:8]);
      load_byte(4 * k + 1, op_a[k][7:0]);
      load_byte(4 * k + 2, op_b[k][15:8]);
      load_byte(4 * k + 3, op_b[k][7:0]);
    end
    for (int i = 0; i < 4 * NP; i++) load_byte(DST + i, fill);
  endtask

  task automatic push_expected();
    for (int k = 0; k < NP; k++) begin
      logic [31:0] p;
      p = 32'(op_a[k]) * 32'(op_b[k]);
      for (int i = 0; i < 4; i++)
        exp_q.push_back('{addr: 8'(DST + 4 * k + i), data: 8'(p >> (24 - 8 * i))});
    end
  endtask

  task automatic randomize_ops();
    for (int k = 0; k < NP; k++) begin
      op_a[k] = 16'($urandom);
      op_b[k] = 16'($urandom);
    end
  endtask

  task automatic start_run(input bit hold);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (!hold) start = 1'b0;
  endtask

  // Returns the cycle number (T0+1 is cycle 1) in which done is first seen high.
  task automatic wait_done(output int n);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 3000);
    n = cyc - t0 + 1;
    if (!done) $display("[TB] FAIL done_timeout: no done after %0d cycles, required by cycle %0d", guard, RUN_LEN + 1);
  endtask

  task automatic applyStimulus(input logic [7:0] fill);
    load_memory(fill);
    push_expected();
    start_run(1'b0);
  endtask

  task automatic checkOutput(input string tag, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      int a;
      a = DST + 4 * k;
      check($sformatf("%s_prod%0d", tag, k), {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]},
            32'(op_a[k]) * 32'(op_b[k]));
    end
  endtask

  task automatic run_and_check(input string tag);
    int n;
    wait_done(n);
    check({tag, "_done_cycle"}, n, RUN_LEN + 1);
    realign();
    check({tag, "_done_held"}, {31'd0, done}, 32'd1);
    checkOutput(tag, 0, NP - 1);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_own_mem", {31'd0, own_mem}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
    rst_n = 1'b1;
    realign();

    // Largest operands in pair 0, zeros elsewhere.
    for (int k = 0; k < NP; k++) begin op_a[k] = 16'h0; op_b[k] = 16'h0; end
    op_a[0] = 16'hFFFF;
    op_b[0] = 16'hFFFF;
    applyStimulus(8'h5A);
    run_and_check("max");
    check("max_bytes", {mem[64], mem[65], mem[66], mem[67]}, 32'hFFFE0001);

    op_a[0] = 16'h0001; op_b[0] = 16'hABCD;
    op_a[1] = 16'h0000; op_b[1] = 16'hFFFF;
    applyStimulus(8'hA5);
    run_and_check("ident");
    check("ident_p0", {mem[64], mem[65], mem[66], mem[67]}, 32'h0000ABCD);
    check("ident_p1", {mem[68], mem[69], mem[70], mem[71]}, 32'h00000000);

    for (int it = 0; it < 10; it++) begin
      randomize_ops();
      applyStimulus(8'($urandom));
      run_and_check($sformatf("rand%0d", it));
    end

    // Start pulses while busy must not disturb the run.
    randomize_ops();
    applyStimulus(8'h00);
    fork
      begin
        repeat (49) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (149) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      begin
        wait_done(n);
      end
    join
    check("pulse_done_cycle", n, RUN_LEN + 1);
    realign();
    checkOutput("pulse", 0, NP - 1);

    // Abort just after pair 3's final write.
    randomize_ops();
    applyStimulus(8'hEE);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
    exp_q.delete();
    checkOutput("abort", 0, 3);
    for (int k = 4; k < NP; k++)
      check($sformatf("abort_untouched%0d", k),
            {mem[DST + 4 * k], mem[DST + 4 * k + 1], mem[DST + 4 * k + 2], mem[DST + 4 * k + 3]},
            32'hEEEEEEEE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    realign();
    randomize_ops();
    applyStimulus(8'h00);
    run_and_check("after_abort");

    // Start held high: two back-to-back runs with a one-cycle done.
    randomize_ops();
    load_memory(8'h33);
    push_expected();
    push_expected();
    start_run(1'b1);
    wait_done(n);
    check("held_done_cycle1", n, RUN_LEN + 1);
    @(negedge clk);
    check("held_done_one_cycle", {31'd0, done}, 32'd0);
    check("held_busy_again", {31'd0, busy}, 32'd1);
    t0 = cyc;
    start = 1'b0;
    wait_done(n);
    check("held_done_cycle2", n, RUN_LEN + 1);
    realign();
    checkOutput("held", 0, NP - 1);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Hardware sequencer for program 3 (double-precision unsigned multiply).
- Walks NUM_PAIRS pairs of 16-bit operands in data memory and multiplies each pair with a 16-iteration shift-add datapath.
- Writes each 32-bit product back to data memory, big-endian, and raises Done.
- Owns the single data-memory port while Busy; external logic muxes the port between this block and the core using Own_mem.

Parameters:
NUM_PAIRS, 16, operand pairs processed per run
SRC_BASE, 0, byte address of first operand
DST_BASE, 64, byte address of first product
AW, 8, data-memory address width

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  level request; sampled in IDLE or DONE
Done  output  1  run complete; held until next run starts or reset
Busy  output  1  run in progress
Own_mem  output  1  equals Busy; selects this block onto the memory port
Mem_addr  output  AW  memory byte address
Mem_wr_en  output  1  write strobe, one byte per cycle
Mem_wr_data  output  8  write data
Mem_rd_data  input  8  read data; registered memory, valid one cycle after Mem_addr

Behaviour:
- Reset low: state IDLE; Done=0, Busy=0, Own_mem=0, Mem_wr_en=0, Mem_addr=0, Mem_wr_data=0; pair counter and accumulator cleared.
- Reset mid-run aborts immediately. Bytes already written stay in memory. No further writes occur.
- States:
  - IDLE: leave on Start=1 at the sampling edge (cycle T0).
  - RD: 5 cycles. Addresses SRC_BASE+4k+0..3 are issued on cycles 1-4 of the state. Bytes are captured one cycle later in order A_hi, A_lo, B_hi, B_lo.
  - MUL: 16 cycles. If mult[0]=1, acc += mcand. Each cycle mcand <<= 1 and mult >>= 1. A is operand 2k and B is operand 2k+1. acc is 32 bits wide and never overflows.
  - WR: 4 cycles with Mem_wr_en=1. Addresses DST_BASE+4k+0..3 receive P[31:24], P[23:16], P[15:8], P[7:0].
  - After WR, k increments. If k = NUM_PAIRS, go to DONE; otherwise return to RD.
  - DONE: Done=1, Busy=0. On Start=1, clear Done, reset k=0 and enter RD.
- Per-pair latency is 25 cycles. With NUM_PAIRS=16:
  - RD of pair 0 occupies T0+1..T0+5.
  - Last write occurs at T0+400.
  - Done=1 from T0+401.
- Busy=1 from T0+1 through T0+400 inclusive.
- Start while Busy is ignored. No restart, no effect on the run.
- Start held high continuously: one run per DONE→RD transition, so a new run begins the cycle after Done rises.
- Mem_wr_en=0 in every state except WR. Mem_addr holds its last value outside RD/WR.
- Address arithmetic wraps modulo 2^AW; no range checking.

Test Plan:
- Pair 0 = 0xFFFF, 0xFFFF; others 0; Start at T0 → mem[64..67] = FF,FE,00,01; all other products 0; Done rises at T0+401.
- Operands 0x0001 × 0xABCD, and 0x0000 × 0xFFFF → products 0x0000ABCD and 0x00000000, bytes big-endian at their DST slots.
- 16 random pairs, 10 iterations with fresh data → every 4-byte product equals A*B from the bench model; Busy high exactly 400 cycles per run; Mem_wr_en high exactly 64 cycles per run.
- Start pulsed again at T0+50 and T0+200 → no effect; single run; Done still at T0+401; results correct.
- Reset driven low at T0+100 → Busy=0, Done=0, Mem_wr_en=0 asynchronously. Pairs 0-3 written, pairs 4-15 untouched. Reset released, then Start → full correct run.
- Start held high through DONE → Done high exactly 1 cycle, then a second identical run; Own_mem tracks Busy every cycle.
